crop_filter: RTL and testbench

- Upstream stage of the normalisation reader in the camera pixel pipeline.
- Captures one frame from the camera pixel stream, keeps only a run-time rectangular ROI, and stores it in an internal buffer.
- Tracks the ROI maximum as the normalisation denominator and pulses cf_ap_done when capture completes.
- Then drains the buffered ROI downstream over AXI-Stream.

---
 rtl/crop_filter_pkg.sv | 16 +
 rtl/crop_filter_roi_buffer_ram.sv | 23 ++
 rtl/crop_filter.sv | 224 ++++++++++++++++++++++
 tb/tb_crop_filter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crop_filter_pkg.sv
// Shared types and constants for the crop_filter ROI capture block.
package crop_filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_CAPTURE,
    ST_DONE,
    ST_DRAIN
  } state_t;

  localparam int SOF_BIT      = 0;
  localparam int EOL_BIT      = 1;
  localparam int NORM_DEN_MIN = 1;

endpackage

// File: rtl/crop_filter_roi_buffer_ram.sv
// ROI pixel store: one write port, one registered read port.
module roi_buffer_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/crop_filter.sv
// Captures a run-time ROI of one camera frame, tracks its max, then drains it.
// Optional CROP_FILTER_STATS_EN adds frame_cnt / drop_cnt outputs.
module crop_filter
  import crop_filter_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int USER_WIDTH      = 2,
  parameter int COORD_WIDTH     = 12,
  parameter int BUF_DEPTH       = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  input  logic [COORD_WIDTH-1:0]     roi_x0,
  input  logic [COORD_WIDTH-1:0]     roi_y0,
  input  logic [COORD_WIDTH-1:0]     roi_w,
  input  logic [COORD_WIDTH-1:0]     roi_h,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  output logic                       roi_overflow
`ifdef CROP_FILTER_STATS_EN
  ,
  output logic [31:0]                frame_cnt,
  output logic [31:0]                drop_cnt
`endif
);

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int CNT_W = 2 * COORD_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [PIXEL_BIT_WIDTH-1:0] DEN_MIN =
    PIXEL_BIT_WIDTH'(NORM_DEN_MIN);

  state_t state, state_n;

  logic [COORD_WIDTH-1:0] x0_r, y0_r, w_r, h_r;
  logic [COORD_WIDTH-1:0] x, y, cx, cy;
  logic [COORD_WIDTH:0]   x_end, y_end;
  logic [CNT_W-1:0]       area, target;
  logic [CNT_W-1:0]       wr_cnt, base_cnt, cnt_inc, rd_cnt;
  logic [PIXEL_BIT_WIDTH-1:0] max_r, base_max, norm_r;
  logic start_ok, beat, sof, eol, proc, in_roi, do_wr;
  logic cap_last;

  logic [PIXEL_BIT_WIDTH-1:0] rd_data;
  logic [PIXEL_BIT_WIDTH-1:0] fd [2];
  logic fl [2];
  logic wp, rp, rd_vld, rd_last, issue, pop;
  logic [1:0] fcnt;
  logic [2:0] need;

  assign start_ok = (state == ST_IDLE) && ap_start;
  assign s_axis_tready = (state != ST_IDLE);
  assign beat = s_axis_tvalid && s_axis_tready;
  assign sof  = s_axis_tuser[SOF_BIT];
  assign eol  = s_axis_tuser[EOL_BIT];

  assign area   = CNT_W'(w_r) * CNT_W'(h_r);
  assign target = (area > DEPTH_C) ? DEPTH_C : area;

  // A SOF beat restarts the frame: it is pixel (0,0) with fresh counters.
  assign proc = beat && ((state == ST_WAIT_SOF && sof) ||
                         (state == ST_CAPTURE && !cap_last));
  assign cx       = sof ? '0 : x;
  assign cy       = sof ? '0 : y;
  assign base_cnt = sof ? '0 : wr_cnt;
  assign base_max = sof ? '0 : max_r;
  assign cnt_inc  = base_cnt + CNT_W'(1);

  assign x_end  = {1'b0, x0_r} + {1'b0, w_r};
  assign y_end  = {1'b0, y0_r} + {1'b0, h_r};
  assign in_roi = ({1'b0, cx} >= {1'b0, x0_r}) && ({1'b0, cx} < x_end) &&
                  ({1'b0, cy} >= {1'b0, y0_r}) && ({1'b0, cy} < y_end);
  assign do_wr  = proc && in_roi && (base_cnt < DEPTH_C);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    ap_done = 1'b0;
    unique case (state)
      ST_IDLE:     if (ap_start) state_n = ST_WAIT_SOF;
      ST_WAIT_SOF: if (proc) state_n = ST_CAPTURE;
      ST_CAPTURE:  if (cap_last) state_n = ST_DONE;
      ST_DONE: begin
        ap_done = 1'b1;
        state_n = ST_DRAIN;
      end
      ST_DRAIN:    if (pop && m_axis_tlast) state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  assign ap_idle = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_r <= '0;
      y0_r <= '0;
      w_r  <= '0;
      h_r  <= '0;
    end else if (start_ok) begin
      x0_r <= roi_x0;
      y0_r <= roi_y0;
      w_r  <= roi_w;
      h_r  <= roi_h;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x        <= '0;
      y        <= '0;
      wr_cnt   <= '0;
      max_r    <= '0;
      cap_last <= 1'b0;
      roi_overflow <= 1'b0;
    end else if (start_ok) begin
      x        <= '0;
      y        <= '0;
      wr_cnt   <= '0;
      max_r    <= '0;
      cap_last <= 1'b0;
      roi_overflow <= 1'b0;
    end else begin
      if (proc) begin
        x      <= eol ? '0 : cx + COORD_WIDTH'(1);
        y      <= eol ? cy + COORD_WIDTH'(1) : cy;
        wr_cnt <= do_wr ? cnt_inc : base_cnt;
        max_r  <= (do_wr && s_axis_tdata > base_max) ?
                  s_axis_tdata : base_max;
        cap_last <= do_wr && (cnt_inc == target);
        if (do_wr && cnt_inc == DEPTH_C && area > DEPTH_C)
          roi_overflow <= 1'b1;
      end
      if (state == ST_DONE) cap_last <= 1'b0;
    end
  end

  // Denominator is loaded on the edge into DONE so it is valid with ap_done.
  always_ff @(posedge clk) begin
    if (reset || start_ok)
      norm_r <= DEN_MIN;
    else if (state == ST_CAPTURE && cap_last)
      norm_r <= (max_r == '0) ? DEN_MIN : max_r;
  end

  assign norm_denominator = norm_r;

  roi_buffer_ram #(
    .WIDTH(PIXEL_BIT_WIDTH),
    .DEPTH(BUF_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (do_wr),
    .waddr(base_cnt[AW-1:0]),
    .wdata(s_axis_tdata),
    .re   (issue),
    .raddr(rd_cnt[AW-1:0]),
    .rdata(rd_data)
  );

  assign m_axis_tvalid = (fcnt != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? fd[rp] : '0;
  assign m_axis_tlast  = m_axis_tvalid && fl[rp];
  assign pop = m_axis_tvalid && m_axis_tready;

  // Reads in flight plus skid contents never exceed the two skid slots.
  assign need  = {1'b0, fcnt} + {2'b0, rd_vld} - {2'b0, pop};
  assign issue = (state == ST_DONE || state == ST_DRAIN) &&
                 (rd_cnt < target) && (need < 3'd2);

  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE) begin
      rd_cnt  <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      wp      <= 1'b0;
      rp      <= 1'b0;
      fcnt    <= 2'd0;
    end else begin
      rd_vld  <= issue;
      rd_last <= issue && (rd_cnt + CNT_W'(1) == target);
      if (issue) rd_cnt <= rd_cnt + CNT_W'(1);
      if (rd_vld) wp <= ~wp;
      if (pop) rp <= ~rp;
      fcnt <= fcnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rd_vld) begin
      fd[wp] <= rd_data;
      fl[wp] <= rd_last;
    end
  end

`ifdef CROP_FILTER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (state == ST_DONE) frame_cnt <= frame_cnt + 32'd1;
      if (s_axis_tvalid && sof &&
          (state == ST_IDLE || state == ST_DRAIN))
        drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crop_filter.sv
// Scoreboard bench for crop_filter with a frame-level reference model.
module tb_crop_filter;

  localparam int PW = 10;
  localparam int UW = 2;
  localparam int CW = 12;
  localparam int BD = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic [CW-1:0] roi_x0, roi_y0, roi_w, roi_h;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [PW-1:0] s_axis_tdata;
  logic [UW-1:0] s_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [PW-1:0] norm_denominator;
  logic          roi_overflow;
`ifdef CROP_FILTER_STATS_EN
  logic [31:0]   frame_cnt, drop_cnt;
`endif

  crop_filter #(
    .PIXEL_BIT_WIDTH(PW),
    .USER_WIDTH(UW),
    .COORD_WIDTH(CW),
    .BUF_DEPTH(BD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_idle(ap_idle),
    .roi_x0(roi_x0),
    .roi_y0(roi_y0),
    .roi_w(roi_w),
    .roi_h(roi_h),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .norm_denominator(norm_denominator),
    .roi_overflow(roi_overflow)
`ifdef CROP_FILTER_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output ready pattern: 0 always, 1 repeating 1-0-0-1, 2 random.
  int rmode = 0;
  int rphase = 0;
  bit [3:0] rpat = 4'b1001;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = rpat[rphase % 4];
        rphase++;
      end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  bit stall_prev = 0;
  int data_prev = 0;
  bit got_done = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit want_first = 0;
  int den_seen = 0;
  int ovf_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
      want_first = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", m_axis_tdata, data_prev);
      end
      if (ap_done) begin
        got_done = 1;
        done_cnt++;
        done_cyc = cyc;
        want_first = 1;
        den_seen = norm_denominator;
        ovf_seen = roi_overflow;
      end else if (want_first && m_axis_tvalid) begin
        chk("first_valid_lat", cyc - done_cyc, 2);
        want_first = 0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0d expected no beat",
                   m_axis_tdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data", m_axis_tdata, e.data);
          chk("last", m_axis_tlast, e.last);
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      data_prev = m_axis_tdata;
    end
  end

  task automatic pulse_start(int x0, int y0, int w, int h);
    @(posedge clk); #1;
    ap_start = 1'b1;
    roi_x0 = CW'(x0);
    roi_y0 = CW'(y0);
    roi_w = CW'(w);
    roi_h = CW'(h);
    @(posedge clk); #1;
    ap_start = 1'b0;
  endtask

  // kind 0: 10*y+x, 1: zero inside ROI, 2: random
  task automatic run_frame(int fw, int fh, int x0, int y0, int w, int h,
                           int kind, int pre, bit restart, int mode);
    int fr[16][16];
    int roi[$];
    int mx;
    int exp_den;
    int exp_ovf;
    rmode = mode;
    for (int yy = 0; yy < fh; yy++)
      for (int xx = 0; xx < fw; xx++) begin
        bit inr;
        inr = xx >= x0 && xx < x0 + w && yy >= y0 && yy < y0 + h;
        case (kind)
          0: fr[yy][xx] = 10 * yy + xx;
          1: fr[yy][xx] = inr ? 0 : 10 * yy + xx + 1;
          default: fr[yy][xx] = int'($urandom_range(0, 1023));
        endcase
        if (inr && roi.size() < BD) roi.push_back(fr[yy][xx]);
      end
    mx = 0;
    foreach (roi[i]) if (roi[i] > mx) mx = roi[i];
    exp_den = (mx == 0) ? 1 : mx;
    exp_ovf = (w * h > BD) ? 1 : 0;
    foreach (roi[i]) begin
      exp_t e;
      e.data = roi[i];
      e.last = (i == roi.size() - 1);
      exp_q.push_back(e);
    end
    chk("idle_before", ap_idle, 1);
    got_done = 0;
    done_cnt = 0;
    pulse_start(x0, y0, w, h);
    fork
      begin
        for (int i = 0; i < pre; i++) begin
          s_axis_tvalid = 1'b1;
          s_axis_tuser = '0;
          s_axis_tdata = PW'(1023);
          @(posedge clk); #1;
        end
        for (int yy = 0; yy < fh; yy++)
          for (int xx = 0; xx < fw; xx++) begin
            if ($urandom_range(0, 3) == 0) begin
              s_axis_tvalid = 1'b0;
              @(posedge clk); #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata = PW'(fr[yy][xx]);
            s_axis_tuser = {xx == fw - 1, xx == 0 && yy == 0};
            @(posedge clk); #1;
          end
        s_axis_tvalid = 1'b0;
        s_axis_tuser = '0;
      end
      begin
        if (restart) begin
          for (int i = 0; i < 2000 && !got_done; i++) @(negedge clk);
          repeat (3) @(posedge clk);
          pulse_start(0, 0, 1, 1);
        end
      end
    join
    for (int i = 0; i < 200 && !got_done; i++) @(negedge clk);
    chk("done_seen", got_done, 1);
    for (int i = 0; i < 400 && !(ap_idle && exp_q.size() == 0); i++)
      @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("den_at_done", den_seen, exp_den);
    chk("overflow", ovf_seen, exp_ovf);
    chk("beats_left", exp_q.size(), 0);
    chk("idle_after", ap_idle, 1);
    chk("den_held", norm_denominator, exp_den);
    if (restart) begin
      repeat (5) @(negedge clk);
      chk("still_idle", ap_idle, 1);
    end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    ap_start = 1'b0;
    roi_x0 = '0;
    roi_y0 = '0;
    roi_w = '0;
    roi_h = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tuser = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", ap_idle, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_den", norm_denominator, 1);
    chk("rst_ovf", roi_overflow, 0);
    chk("rst_sready", s_axis_tready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(8, 4, 2, 1, 3, 2, 0, 0, 0, 0);
    run_frame(8, 4, 2, 1, 3, 2, 0, 0, 0, 1);
    run_frame(8, 4, 2, 1, 3, 2, 1, 0, 0, 0);
    run_frame(8, 6, 1, 1, 5, 4, 0, 0, 0, 2);

    // abort a capture part-way through with reset
    pulse_start(2, 1, 3, 2);
    for (int i = 0; i < 12; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = PW'(900 + i);
      s_axis_tuser = {i % 8 == 7, i == 0};
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", ap_idle, 1);
    chk("abort_mvalid", m_axis_tvalid, 0);
    chk("abort_den", norm_denominator, 1);
    run_frame(8, 4, 2, 1, 3, 2, 2, 0, 0, 0);

    run_frame(8, 4, 2, 1, 3, 2, 0, 2, 1, 1);

    for (int t = 0; t < 8; t++) begin
      int fw, fh, x0, y0, w, h;
      fw = int'($urandom_range(3, 12));
      fh = int'($urandom_range(2, 8));
      x0 = int'($urandom_range(0, fw - 1));
      y0 = int'($urandom_range(0, fh - 1));
      w = int'($urandom_range(1, fw - x0));
      h = int'($urandom_range(1, fh - y0));
      run_frame(fw, fh, x0, y0, w, h, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), 0,
                int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
